// File: rtl/sseg_disp_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-slot guard
// blanking and a double-buffered pattern store committed at frame wrap.
module sseg_disp_mux #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [8*N_DIGITS-1:0]   in_sseg,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    logic [TICK_W-1:0]   tick_cnt;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          shadow [N_DIGITS];
    logic [7:0]          active [N_DIGITS];
    logic                pending;
    logic                wrapped;

    logic                slot_end;
    logic                frame_wrap;
    logic                commit;
    phase_t              phase;
    logic [N_DIGITS-1:0] an_nxt;
    logic [7:0]          sseg_nxt;

    always_comb begin
        slot_end   = (tick_cnt == TICK_LAST);
        frame_wrap = en && slot_end && (idx == IDX_LAST);
        // While disabled every cycle is a commit point, so held data lands promptly.
        commit     = frame_wrap || !en;
        phase      = (en && tick_cnt >= TICK_BLANK) ? PH_SHOW : PH_BLANK;
        an_nxt     = '1;
        sseg_nxt   = '1;
        if (phase == PH_SHOW) begin
            an_nxt[idx] = 1'b0;
            sseg_nxt    = active[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt   <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            wrapped    <= 1'b0;
            an         <= '1;
            sseg       <= '1;
            frame_tick <= 1'b0;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                shadow[i] <= '1;
                active[i] <= '1;
            end
        end else begin
            if (en) begin
                tick_cnt <= slot_end ? '0 : tick_cnt + TICK_W'(1);
                if (slot_end)
                    idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                tick_cnt <= '0;
                idx      <= '0;
            end

            if (load) begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    shadow[i] <= in_sseg[8*i +: 8];
            end

            // A load coinciding with a commit bypasses the shadow buffer.
            if (commit && load) begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    active[i] <= in_sseg[8*i +: 8];
                pending <= 1'b0;
            end else if (commit && pending) begin
                for (int unsigned i = 0; i < N_DIGITS; i++)
                    active[i] <= shadow[i];
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            wrapped    <= frame_wrap;
            frame_tick <= wrapped && en;
            an         <= an_nxt;
            sseg       <= sseg_nxt;
        end
    end

endmodule

// File: doc/sseg_disp_mux.md
# sseg_disp_mux

Time-multiplexed driver for a multi-digit common-anode seven-segment display. It takes the per-digit 8-bit segment patterns produced by the hex-to-segment encoders and scans them one digit at a time onto the shared segment lines and per-digit anode enables. A guard blanking interval at every digit switch prevents ghosting. New patterns are double-buffered so a displayed frame never tears. The block sits between the counter/encoder datapath and the board's display pins.

## Interface
- N_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; ≥ 2.
- BLANK_CYCLES, 16: blanked cycles at the start of each slot; legal range 1..REFRESH_DIV-1.

- clk  input  1  system clock; single clock domain.
- reset_n  input  1  synchronous, active-low reset.
- en  input  1  scan enable; low blanks the display.
- load  input  1  one-cycle strobe; captures in_sseg into the shadow buffer.
- in_sseg  input  8*N_DIGITS  digit i pattern is in_sseg[8i+7:8i]; bit 7 is dp, bits 6:0 are segments a..g; all active-low.
- an  output  N_DIGITS  anode enables, active-low, at most one bit low.
- sseg  output  8  segment lines, active-low; bit 7 is dp.
- frame_tick  output  1  one-cycle pulse at each frame wrap (last digit → digit 0).

## Operation
- Storage: shadow[N] and active[N] pattern registers, plus a pending flag.
- Counters: tick_cnt (0..REFRESH_DIV-1) and digit index idx (0..N_DIGITS-1).
- Reset values: an all 1, sseg 8'hFF, frame_tick 0, tick_cnt 0, idx 0, shadow and active all 8'hFF, pending 0.
- load=1: shadow ← in_sseg and pending ← 1. A new load overwrites an uncommitted shadow.
- Scan (en=1):
  - tick_cnt increments each cycle.
  - At REFRESH_DIV-1, tick_cnt wraps to 0 and idx advances.
  - idx wraps from N_DIGITS-1 to 0; this wrap is the commit point.
- Per-slot phases:
  - BLANK while tick_cnt < BLANK_CYCLES: an all 1, sseg 8'hFF.
  - SHOW otherwise: an[idx]=0, other bits 1, sseg = active[idx].
- Commit: at the idx wrap, if pending, then active ← shadow and pending ← 0. frame_tick pulses at every wrap, whether or not pending is set.
- Simultaneous load and commit: active ← in_sseg directly; pending ends 0.
- en=0:
  - tick_cnt and idx are forced to 0; outputs are blank.
  - A pending shadow commits on the next cycle; a load while disabled commits on the cycle after it.
  - No frame_tick is generated.
- en rising: scanning restarts at digit 0, BLANK phase, tick_cnt 0.
- Segment data passes through unmodified: no decoding or polarity inversion, and dp is passed as given.

## Timing
- Outputs are registered. an, sseg and frame_tick in cycle t reflect tick_cnt, idx, active and en of cycle t-1.
- Slot length is exactly REFRESH_DIV cycles. Frame length is N_DIGITS×REFRESH_DIV cycles.
- Each slot has exactly BLANK_CYCLES blank cycles followed by REFRESH_DIV-BLANK_CYCLES lit cycles.
- Loaded data shows on the first SHOW phase of digit 0 after the next commit, never mid-frame.
- frame_tick coincides with the first BLANK output cycle of digit 0.
- reset_n low mid-operation: on the next edge all state returns to the reset values, regardless of en or load. Scanning resumes from digit 0 once reset_n is high.
- an never has two bits low, including across slot boundaries, enable toggles and reset.

## Test plan
Common setup: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2. Patterns: 0→8'h81, 1→8'hCF, 2→8'h92, 3→8'h86 (dp off).

- Reset: reset_n=0 for 5 cycles with en=1, load=1, in_sseg=32'h8692CF81 → an=4'hF, sseg=8'hFF, frame_tick=0 every cycle; after release, the first frame shows blank patterns.
- Basic scan: with en=0, load 32'h8692CF81, then set en=1 → repeating sequence:
  - 2 cycles an=F / sseg=FF, then 6 cycles an=E / sseg=81;
  - 2 blank cycles, then 6 cycles an=D / sseg=CF;
  - 2 blank cycles, then 6 cycles an=B / sseg=92;
  - 2 blank cycles, then 6 cycles an=7 / sseg=86;
  - frame_tick pulses every 32 cycles.
- Deferred update: during the digit 1 slot, load 32'h86868686 → digits 1–3 still show CF/92/86 this frame; all digits show 86 from the next frame.
- Simultaneous load and commit: pulse load with in_sseg=32'hFFFFFF00 on the wrap cycle → digit 0 shows sseg=00 in that same frame's SHOW phase; no extra update occurs in the following frame.
- Enable drop: drop en to 0 at cycle 4 of the digit 2 slot → outputs blank on the next cycle. Re-enable after 10 cycles → 2 blank cycles, then an=E; no frame_tick while disabled.
- Mid-operation reset: pulse reset_n low for 1 cycle during a SHOW phase → an=F, sseg=FF on the next edge; active is cleared, so digits show FF until a new load commits.
